// File: rtl/mux_scan_reg.sv
// Registered N-channel, W-bit multiplexer with manual select and auto-scan (dwell per channel).
// Optional even-parity output dout_par when MUX_PARITY_EN is defined.
//
// state  | meaning
// MANUAL | output follows sel; the next scan entry starts with a fresh dwell count
// SCAN   | output follows the internal channel pointer, advancing every DWELL enabled cycles
module mux_scan_reg #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2,
  parameter int DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  input  logic                 en,
  output logic [WIDTH-1:0]     dout,
  output logic [SELW-1:0]      dout_ch,
  output logic                 dout_valid,
  output logic                 wrap
`ifdef MUX_PARITY_EN
  ,
  output logic                 dout_par
`endif
);

  localparam int DW = $clog2(DWELL) + 1;
  localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
  localparam logic [SELW:0]   NCH_X      = (SELW + 1)'(NCH);
  localparam logic [SELW-1:0] LAST_CH    = SELW'(NCH - 1);

  typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_t;

  state_t            state, state_nxt;
  logic              fresh_scan;
  logic [SELW-1:0]   cur_ch;
  logic [DW-1:0]     dwell_cnt;
  logic [DW-1:0]     dwell_eff;
  logic              sel_legal;
  logic [SELW-1:0]   rd_ch;
  logic [WIDTH-1:0]  rd_data;
  logic [WIDTH-1:0]  load_data;

  always_ff @(posedge clk) begin
    if (rst) state <= MANUAL;
    else     state <= state_nxt;
  end

  // Mode is only sampled on enabled edges, so a change while paused waits for en.
  always_comb begin
    state_nxt = state;
    case (state)
      MANUAL: if (en && mode)  state_nxt = SCAN;
      SCAN:   if (en && !mode) state_nxt = MANUAL;
      default: state_nxt = MANUAL;
    endcase
  end

  always_comb begin
    fresh_scan = (state == MANUAL);
  end

  always_comb begin
    sel_legal = ({1'b0, sel} < NCH_X);
    rd_ch     = mode ? cur_ch : sel;
    rd_data   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (rd_ch == SELW'(k)) rd_data = din[k*WIDTH +: WIDTH];
    end
    load_data = (mode || sel_legal) ? rd_data : '0;
    dwell_eff = fresh_scan ? '0 : dwell_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
      wrap       <= 1'b0;
      cur_ch     <= '0;
      dwell_cnt  <= '0;
    end else if (!en) begin
      dout_valid <= 1'b0;
      wrap       <= 1'b0;
    end else if (!mode) begin
      dout       <= load_data;
      dout_ch    <= sel;
      dout_valid <= sel_legal;
      cur_ch     <= sel_legal ? sel : '0;
      dwell_cnt  <= '0;
      wrap       <= 1'b0;
    end else begin
      dout       <= load_data;
      dout_ch    <= cur_ch;
      dout_valid <= 1'b1;
      if (dwell_eff == DWELL_LAST) begin
        dwell_cnt <= '0;
        cur_ch    <= (cur_ch == LAST_CH) ? '0 : cur_ch + 1'b1;
        wrap      <= (cur_ch == LAST_CH);
      end else begin
        dwell_cnt <= dwell_eff + 1'b1;
        wrap      <= 1'b0;
      end
    end
  end

`ifdef MUX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)     dout_par <= 1'b0;
    else if (en) dout_par <= ^load_data;
  end
`endif

endmodule

// File: doc/mux_scan_reg.md
Name: mux_scan_reg

Overview:
Parametrised N-channel, W-bit registered multiplexer. Generalises the combinational 4:1 mux to any width and channel count. Adds a manual-select mode and an auto-scan mode: in auto-scan an internal channel pointer cycles through all inputs, staying on each for a programmable dwell time. Sits between parallel data sources (switches, sensors, counters) and a single shared consumer, such as a display driver or serial transmitter.

Parameters:
- WIDTH, 8, bits per channel.
- NCH, 4, number of input channels (>=2).
- SELW, 2, select width; must satisfy 2**SELW >= NCH.
- DWELL, 4, enabled cycles spent on each channel in auto-scan (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- din  input  NCH*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SELW  manual channel select.
- mode  input  1  0 = manual, 1 = auto-scan.
- en  input  1  advance/sample enable.
- dout  output  WIDTH  registered selected data.
- dout_ch  output  SELW  channel index that dout came from.
- dout_valid  output  1  dout updated this cycle with a legal channel.
- wrap  output  1  one-cycle pulse on the last dwell sample of channel NCH-1 in auto-scan.

Behaviour:
- Reset (rst=1 at a clock edge):
  - dout=0, dout_ch=0, dout_valid=0, wrap=0.
  - Internal cur_ch=0, dwell_cnt=0.
  - Reset overrides en and mode, and aborts any scan in progress.
- Latency: one clock from din/sel to dout. All outputs are registered; no combinational path from inputs to outputs.
- en=0:
  - dout, dout_ch, cur_ch and dwell_cnt hold their values.
  - dout_valid=0, wrap=0.
- Manual mode (mode=0, en=1):
  - sel < NCH: dout<=din[sel], dout_ch<=sel, dout_valid<=1.
  - sel >= NCH: dout<=0, dout_ch<=sel, dout_valid<=0.
  - Every manual cycle: cur_ch<=sel if sel < NCH (else 0), dwell_cnt<=0, wrap<=0.
- Auto-scan mode (mode=1, en=1), every cycle:
  - dout<=din[cur_ch], dout_ch<=cur_ch, dout_valid<=1.
  - If dwell_cnt==DWELL-1:
    - dwell_cnt<=0.
    - cur_ch<=(cur_ch==NCH-1)?0:cur_ch+1.
    - wrap<=(cur_ch==NCH-1).
  - Otherwise: dwell_cnt<=dwell_cnt+1, wrap<=0.
- Scan state machine, two states:
  - MANUAL: transitions to SCAN when mode=1 at an enabled edge. The scan starts from the last legal manual channel with a fresh dwell count.
  - SCAN: transitions to MANUAL when mode=0. Takes effect on the same edge; the output follows sel immediately.
  - A mode change while en=0 takes effect at the next enabled edge.
- DWELL=1: channel advances every enabled cycle; wrap is asserted every NCH enabled cycles.
- Pausing: en dropping mid-dwell freezes dwell_cnt. The scan resumes exactly where it stopped.
- Widths:
  - dwell_cnt is sized by $clog2(DWELL)+1.
  - cur_ch is SELW bits and never holds a value >= NCH.
- din changing mid-dwell: the new value is captured on the next enabled edge. There is no sample-and-hold per dwell.

Optional Feature:
Macro MUX_PARITY_EN.
- Defined: adds output port dout_par (1 bit, registered alongside dout).
  - dout_par = XOR reduction of the value loaded into dout (even parity).
  - Reset value 0; holds when en=0.
- Not defined: port absent; no parity logic. All other behaviour is identical.

Test Plan:
1. Reset: drive rst=1 for 2 cycles with en=1, mode=1, din nonzero -> dout=0, dout_ch=0, dout_valid=0, wrap=0. After release, first sample dout=din[0].
2. Manual select (WIDTH=8, NCH=4, din={8'hD4,8'hC3,8'hB2,8'hA1}, mode=0, en=1), sel=0,1,2,3 on successive cycles -> one cycle later dout=A1,B2,C3,D4; dout_ch=0..3; dout_valid=1.
3. Illegal select (NCH=3, SELW=2, sel=3, en=1) -> dout=0, dout_valid=0, dout_ch=3. Next cycle with sel=1 -> dout=din[1], dout_valid=1.
4. Auto-scan (DWELL=4, NCH=4, en=1, 16 cycles):
   - dout_ch sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3, then back to 0.
   - wrap=1 only on the 16th sample.
5. Pause and mode switch:
   - In scan at ch2 after 2 dwell samples, drop en for 5 cycles -> outputs hold, dout_valid=0. Re-enable -> 2 more ch2 samples, then ch3.
   - Then mode=0 with sel=1 -> next dout_ch=1. Back to mode=1 -> scan starts at ch1 with a full 4-cycle dwell.
6. MUX_PARITY_EN defined:
   - dout=8'hA1 -> dout_par=1.
   - dout=8'hC3 -> dout_par=0.
   - Without the macro, the bench builds with the port omitted.
